// File: rtl/core_pkg.sv
// Shared fetch-stage types: FSM state encoding, bubble instruction and IF/ID register layout.
package core_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage and its surroundings: pipeline control, instruction memory and IF/ID outputs.
interface fetch_unit_if;

    logic        i_stall;
    logic        i_flush;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_pc;
    logic [31:0] i_instr;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_instr;
    logic        o_id_valid;
    logic        o_fault;
    logic [31:0] o_fault_pc;
    logic [31:0] o_fetch_cnt;

    modport master (
        input  i_stall, i_flush, i_redirect, i_redirect_pc, i_instr,
        output o_pc, o_id_pc, o_id_instr, o_id_valid, o_fault, o_fault_pc, o_fetch_cnt
    );

    modport slave (
        output i_stall, i_flush, i_redirect, i_redirect_pc, i_instr,
        input  o_pc, o_id_pc, o_id_instr, o_id_valid, o_fault, o_fault_pc, o_fetch_cnt
    );

endinterface

// File: rtl/pc_next.sv
// Candidate next PC (redirect target or sequential) plus misalignment / out-of-range fault detection.
module pc_next #(
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] cand_o,
    output logic        fault_o
);

    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    // A sequential wrap past 32'hFFFF_FFFC can never be reached: the limit check fires long before.
    always_comb begin
        cand_o  = redirect_i ? redirect_pc_i : pc_i + 32'd4;
        fault_o = (cand_o[1:0] != 2'b00) || (cand_o >= PC_LIMIT);
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC register, BOOT/RUN/HALT control, IF/ID register and delivery counter.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    fetch_unit_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    if_id_t       ifId_q, ifId_d;
    logic         fault_q, fault_d;
    logic [31:0]  faultPc_q, faultPc_d;
    logic [31:0]  fetchCnt_q, fetchCnt_d;
    logic [31:0]  candPc;
    logic         candFault;

    pc_next #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_next (
        .pc_i          (pc_q),
        .redirect_i    (bus.i_redirect),
        .redirect_pc_i (bus.i_redirect_pc),
        .cand_o        (candPc),
        .fault_o       (candFault)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            ifId_q     <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
            fault_q    <= 1'b0;
            faultPc_q  <= 32'd0;
            fetchCnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ifId_q     <= ifId_d;
            fault_q    <= fault_d;
            faultPc_q  <= faultPc_d;
            fetchCnt_q <= fetchCnt_d;
        end
    end

    // Fault beats redirect beats stall; flush only affects IF/ID, so flush+stall bubbles while the PC holds.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifId_d     = ifId_q;
        fault_d    = fault_q;
        faultPc_d  = faultPc_q;
        fetchCnt_d = fetchCnt_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (candFault) begin
                    state_d   = HALT;
                    fault_d   = 1'b1;
                    faultPc_d = candPc;
                    ifId_d    = '{pc: pc_q, instr: NOP_INSTR, valid: 1'b0};
                end else begin
                    if (bus.i_redirect || bus.i_flush) begin
                        ifId_d = '{pc: pc_q, instr: NOP_INSTR, valid: 1'b0};
                    end else if (!bus.i_stall) begin
                        ifId_d     = '{pc: pc_q, instr: bus.i_instr, valid: 1'b1};
                        fetchCnt_d = fetchCnt_q + 32'd1;
                    end
                    if (bus.i_redirect || !bus.i_stall) begin
                        pc_d = candPc;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign bus.o_pc        = pc_q;
    assign bus.o_id_pc     = ifId_q.pc;
    assign bus.o_id_instr  = ifId_q.instr;
    assign bus.o_id_valid  = ifId_q.valid;
    assign bus.o_fault     = fault_q;
    assign bus.o_fault_pc  = faultPc_q;
    assign bus.o_fetch_cnt = fetchCnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference model plus a delivery scoreboard.
module tb_fetch_unit;
    import core_pkg::*;

    localparam int unsigned IMEM_WORDS = 256;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } delivery_t;

    logic clk  = 1'b0;
    logic rstN = 1'b1;

    fetch_unit_if intf ();

    logic [31:0] imem [IMEM_WORDS];
    delivery_t   sbQueue [$];

    int checkCount = 0;
    int passCount  = 0;

    fetch_state_e mState;
    logic [31:0]  mPc, mIdPc, mIdInstr, mFaultPc, mCnt, lastCnt;
    logic         mIdValid, mFault;

    always #5 clk = ~clk;

    assign intf.i_instr = (intf.o_pc < 32'(4 * IMEM_WORDS)) ? imem[intf.o_pc[9:2]] : 32'hDEAD_BEEF;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (intf)
    );

    function automatic logic [31:0] patternWord(input logic [31:0] addr);
        return 32'hA000_0000 | (addr >> 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    task automatic compareAll();
        delivery_t d;
        checkOutput("pc", intf.o_pc, mPc);
        checkOutput("idValid", 32'(intf.o_id_valid), 32'(mIdValid));
        if (mState != HALT) begin
            checkOutput("idPc", intf.o_id_pc, mIdPc);
            checkOutput("idInstr", intf.o_id_instr, mIdInstr);
        end
        checkOutput("fault", 32'(intf.o_fault), 32'(mFault));
        checkOutput("faultPc", intf.o_fault_pc, mFaultPc);
        checkOutput("fetchCnt", intf.o_fetch_cnt, mCnt);
        if (intf.o_fetch_cnt !== lastCnt) begin
            checkOutput("sbDepth", 32'(sbQueue.size()), 32'd1);
            if (sbQueue.size() > 0) begin
                d = sbQueue.pop_front();
                checkOutput("sbPc", intf.o_id_pc, d.pc);
                checkOutput("sbInstr", intf.o_id_instr, d.instr);
            end
            lastCnt = intf.o_fetch_cnt;
        end
    endtask

    task automatic modelReset();
        mState   = BOOT;
        mPc      = RESET_PC;
        mIdPc    = 32'd0;
        mIdInstr = NOP_INSTR;
        mIdValid = 1'b0;
        mFault   = 1'b0;
        mFaultPc = 32'd0;
        mCnt     = 32'd0;
        lastCnt  = 32'd0;
        sbQueue.delete();
    endtask

    // Reset lands between edges; a pending redirect is driven alongside it and must be ignored.
    task automatic resetDut(input logic pendRedirect, input logic [31:0] pendTarget);
        #1;
        intf.i_stall       = 1'b0;
        intf.i_flush       = 1'b0;
        intf.i_redirect    = pendRedirect;
        intf.i_redirect_pc = pendTarget;
        rstN = 1'b0;
        modelReset();
        #1;
        compareAll();
        @(posedge clk);
        #1;
        compareAll();
        intf.i_redirect = 1'b0;
        #1;
        rstN = 1'b1;
    endtask

    task automatic applyStimulus(input logic stall, input logic flush, input logic redirect,
                                 input logic [31:0] target);
        logic [31:0] cand;
        @(negedge clk);
        intf.i_stall       = stall;
        intf.i_flush       = flush;
        intf.i_redirect    = redirect;
        intf.i_redirect_pc = target;
        case (mState)
            BOOT: mState = RUN;
            RUN: begin
                cand = redirect ? target : mPc + 32'd4;
                if ((cand[1:0] != 2'b00) || (cand >= 32'(4 * IMEM_WORDS))) begin
                    mState   = HALT;
                    mFault   = 1'b1;
                    mFaultPc = cand;
                    mIdValid = 1'b0;
                end else begin
                    if (redirect || flush) begin
                        mIdPc    = mPc;
                        mIdInstr = NOP_INSTR;
                        mIdValid = 1'b0;
                    end else if (!stall) begin
                        mIdPc    = mPc;
                        mIdInstr = patternWord(mPc);
                        mIdValid = 1'b1;
                        mCnt     = mCnt + 32'd1;
                        sbQueue.push_back('{pc: mPc, instr: patternWord(mPc)});
                    end
                    if (redirect) mPc = target;
                    else if (!stall) mPc = mPc + 32'd4;
                end
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < int'(IMEM_WORDS); i++) imem[i] = 32'hA000_0000 | 32'(i);
        intf.i_stall       = 1'b0;
        intf.i_flush       = 1'b0;
        intf.i_redirect    = 1'b0;
        intf.i_redirect_pc = 32'd0;

        resetDut(1'b0, 32'd0);
        applyStimulus(0, 0, 0, 32'd0);
        repeat (4) applyStimulus(0, 0, 0, 32'd0);

        repeat (3) applyStimulus(1, 0, 0, 32'd0);
        repeat (2) applyStimulus(0, 0, 0, 32'd0);

        applyStimulus(0, 0, 1, 32'h08);
        applyStimulus(0, 0, 1, 32'h40);
        repeat (2) applyStimulus(0, 0, 0, 32'd0);

        applyStimulus(1, 0, 1, 32'h60);
        repeat (2) applyStimulus(0, 0, 0, 32'd0);

        repeat (2) applyStimulus(1, 1, 0, 32'd0);
        applyStimulus(0, 0, 0, 32'd0);
        applyStimulus(0, 1, 0, 32'd0);
        repeat (2) applyStimulus(0, 0, 0, 32'd0);

        applyStimulus(0, 0, 1, 32'h80);
        resetDut(1'b1, 32'h200);
        repeat (3) applyStimulus(0, 0, 0, 32'd0);

        applyStimulus(0, 0, 1, 32'h42);
        applyStimulus(0, 0, 0, 32'd0);
        applyStimulus(0, 0, 1, 32'h100);

        resetDut(1'b0, 32'd0);
        repeat (2) applyStimulus(0, 0, 0, 32'd0);
        applyStimulus(0, 0, 1, 32'h400);
        applyStimulus(0, 0, 0, 32'd0);

        resetDut(1'b0, 32'd0);
        applyStimulus(0, 0, 0, 32'd0);
        applyStimulus(0, 0, 1, 32'h3F8);
        repeat (3) applyStimulus(0, 0, 0, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core. Owns the program counter and drives it to the instruction memory, whose word read is combinational. Captures the returned word together with its PC into an IF/ID register for the decoder. Handles sequential increment, branch/jump redirect, stall, flush, and fault halting on misaligned or out-of-range fetch addresses.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_WORDS, 256: instruction memory depth in words. Legal PCs are 0 to 4*IMEM_WORDS-4.
- NOP_INSTR, 32'h0000_0013: bubble encoding (addi x0,x0,0).

Ports:
- i_clk, in, 1: clock, rising edge.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_stall, in, 1: hold the PC and the IF/ID register.
- i_flush, in, 1: replace the IF/ID content with a bubble.
- i_redirect, in, 1: taken branch or jump.
- i_redirect_pc, in, 32: redirect target.
- o_pc, out, 32: fetch address to instruction memory (registered).
- i_instr, in, 32: instruction word from memory, valid in the same cycle as o_pc.
- o_id_pc, out, 32: PC of the instruction in IF/ID.
- o_id_instr, out, 32: instruction in IF/ID.
- o_id_valid, out, 1: IF/ID holds a real instruction.
- o_fault, out, 1: sticky fetch fault.
- o_fault_pc, out, 32: offending address.
- o_fetch_cnt, out, 32: count of instructions delivered to IF/ID.

## Operation
States:
- BOOT: one cycle after reset release. o_pc = RESET_PC and the memory read is in flight. No IF/ID capture; the state always advances to RUN.
- RUN: normal fetching.
- HALT: entered on a fault. PC frozen, o_id_valid = 0, left only by reset.

Next-PC selection in RUN, in priority order:
1. Fault on the candidate next PC goes to HALT. The candidate is i_redirect_pc if i_redirect, else o_pc+4. A fault is candidate[1:0] != 0, or candidate >= 4*IMEM_WORDS. On a fault, o_fault_pc = candidate and o_fault = 1.
2. i_redirect: PC = i_redirect_pc, and IF/ID becomes a bubble. Redirect overrides i_stall.
3. i_stall: PC and IF/ID hold.
4. Otherwise: PC = o_pc+4.

IF/ID update in RUN, evaluated at each edge:
- Redirect or i_flush: bubble. That is id_instr = NOP_INSTR, id_valid = 0, and id_pc = o_pc.
- i_stall without redirect or flush: hold. If i_flush and i_stall are both high, flush wins on IF/ID while the PC still holds.
- Otherwise: capture {o_pc, i_instr} with valid = 1, and increment o_fetch_cnt.

Arithmetic:
- PC+4 is a 32-bit add. Wrap at 32'hFFFF_FFFC is caught by the range check before it takes effect.
- o_fetch_cnt wraps modulo 2^32.

Reset values:
- o_pc = RESET_PC
- o_id_pc = 0, o_id_instr = NOP_INSTR, o_id_valid = 0
- o_fault = 0, o_fault_pc = 0, o_fetch_cnt = 0
- State = BOOT

Reset mid-operation restores all of the above immediately (asynchronous), and any in-flight redirect is discarded.

## Timing
- Fetch latency: the instruction at PC X appears on o_id_* one edge after o_pc = X, provided there is no stall.
- First valid IF/ID occurs on the second rising edge after reset deassertion (BOOT then RUN).
- Redirect asserted in cycle n: o_pc = target after edge n, and o_id_valid = 0 after edge n. The target instruction is valid after edge n+1, so the redirect penalty is one bubble.
- All outputs are registered; there are no combinational input-to-output paths.
- i_stall, i_flush and i_redirect are sampled at the rising edge only.

## Structure
- The shared package core_pkg holds:
  - the fetch_state_e enum (BOOT, RUN, HALT)
  - the localparam NOP_INSTR
  - the if_id_t struct {pc, instr, valid}
- One sub-module, pc_next, is natural: a combinational candidate-PC and fault-detect block.
- Everything else lives in fetch_unit: the state register, PC register, IF/ID register and counter.

## Test plan
- Reset release with RESET_PC = 0 and a memory preloaded with an incrementing pattern -> after edge 2: o_id_pc = 0, o_id_valid = 1; after edge 3: o_id_pc = 4; o_fetch_cnt = 2.
- i_stall for 3 cycles at PC 0x10 -> o_pc stays 0x10 and the IF/ID contents are unchanged. On release, 0x14 follows with no lost or duplicated instruction.
- i_redirect with target 0x40 while PC = 0x08 -> next o_pc = 0x40 and o_id_valid = 0 for one cycle, then o_id_pc = 0x40 with valid = 1.
- Redirect and stall asserted in the same cycle -> redirect wins: o_pc = target and a bubble is inserted. With i_flush and i_stall both high -> a bubble is inserted and the PC holds.
- Redirect to 0x42 -> o_fault = 1, o_fault_pc = 0x42, HALT. Redirect to 0x400 with IMEM_WORDS = 256 -> fault. Sequential fetch from 0x3FC -> fault with o_fault_pc = 0x400.
- Assert i_rst_n low mid-stream at PC 0x80 with a pending redirect -> all outputs return to their reset values immediately and the redirect is ignored.
